// File: rtl/tia_fb_writer_if.sv
// Video-in / framebuffer-out signal bundle for tia_fb_writer.
// master = pixel source and framebuffer sink; slave = the writer itself.
interface tia_fb_writer_if;
  logic        pix_en;
  logic [6:0]  pix_data;
  logic        hsync;
  logic        vsync;
  logic [15:0] fb_addr;
  logic [6:0]  fb_data;
  logic        fb_we;
  logic        frame_done;

  modport master (
    output pix_en, pix_data, hsync, vsync,
    input  fb_addr, fb_data, fb_we, frame_done
  );

  modport slave (
    input  pix_en, pix_data, hsync, vsync,
    output fb_addr, fb_data, fb_we, frame_done
  );
endinterface

// File: rtl/tia_fb_writer.sv
// Captures the visible TIA pixel stream into a line-major framebuffer.
// Optional macro FB_CLEAR_EN: zero-fill the unwritten tail of a short frame.
module tia_fb_writer #(
  parameter int unsigned LINE_PIXELS = 160,
  parameter int unsigned NUM_LINES   = 240,
  parameter int unsigned FIRST_LINE  = 40
) (
  input  logic             clk,
  input  logic             reset,
  tia_fb_writer_if.slave   bus
);

  localparam int unsigned AW     = 16;
  localparam int unsigned COL_W  = $clog2(LINE_PIXELS + 1);
  localparam int unsigned LINE_W = $clog2(NUM_LINES + 1);
  localparam int unsigned SKIP_W = (FIRST_LINE > 0) ? $clog2(FIRST_LINE + 1) : 1;
`ifdef FB_CLEAR_EN
  localparam int unsigned TOTAL  = LINE_PIXELS * NUM_LINES;
`endif

  typedef enum logic [2:0] {
    WAIT_VS,
    SKIP,
    ACTIVE,
    DONE
`ifdef FB_CLEAR_EN
    , CLEAR
`endif
  } state_t;

  state_t              state_q;
  logic                vs_q;
  logic [SKIP_W-1:0]   skip_q;
  logic [LINE_W-1:0]   line_q;
  logic [COL_W-1:0]    col_q;
  logic [AW-1:0]       base_q;
  logic                we_q;
  logic [AW-1:0]       addr_q;
  logic [6:0]          data_q;
  logic                done_q;

  logic                vs_fall;
  logic                vs_rise;
  logic                col_ok;
  logic [LINE_W-1:0]   line_nxt;
  logic [SKIP_W-1:0]   skip_nxt;

  assign vs_fall  = vs_q & ~bus.vsync;
  assign vs_rise  = ~vs_q & bus.vsync;
  assign col_ok   = col_q < COL_W'(LINE_PIXELS);
  assign line_nxt = line_q + LINE_W'(1);
  assign skip_nxt = skip_q + SKIP_W'(1);

  // base_q tracks line*LINE_PIXELS by accumulation; in CLEAR it doubles as the fill pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= WAIT_VS;
      vs_q    <= 1'b0;
      skip_q  <= '0;
      line_q  <= '0;
      col_q   <= '0;
      base_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      vs_q   <= bus.vsync;
      we_q   <= 1'b0;
      done_q <= 1'b0;
      if (vs_fall) begin
        skip_q  <= '0;
        line_q  <= '0;
        col_q   <= '0;
        base_q  <= '0;
        state_q <= (FIRST_LINE == 0) ? ACTIVE : SKIP;
      end else begin
        case (state_q)
          SKIP: begin
            if (bus.hsync) begin
              skip_q <= skip_nxt;
              if (skip_nxt == SKIP_W'(FIRST_LINE)) begin
                line_q  <= '0;
                col_q   <= '0;
                base_q  <= '0;
                state_q <= ACTIVE;
              end
            end
          end
          ACTIVE: begin
            if (vs_rise) begin
`ifdef FB_CLEAR_EN
              base_q  <= base_q + AW'(col_q);
              state_q <= CLEAR;
`else
              state_q <= WAIT_VS;
`endif
            end else if (bus.hsync) begin
              col_q  <= '0;
              base_q <= base_q + AW'(LINE_PIXELS);
              line_q <= line_nxt;
              if (line_nxt == LINE_W'(NUM_LINES)) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end else if (bus.pix_en) begin
                // pixel coincident with hsync lands at column 0 of the new line
                we_q   <= 1'b1;
                addr_q <= base_q + AW'(LINE_PIXELS);
                data_q <= bus.pix_data;
                col_q  <= COL_W'(1);
              end
            end else if (bus.pix_en && col_ok) begin
              we_q   <= 1'b1;
              addr_q <= base_q + AW'(col_q);
              data_q <= bus.pix_data;
              col_q  <= col_q + COL_W'(1);
            end
          end
          DONE, WAIT_VS: begin
            if (vs_rise) state_q <= WAIT_VS;
          end
`ifdef FB_CLEAR_EN
          CLEAR: begin
            if ({1'b0, base_q} >= (AW+1)'(TOTAL)) begin
              state_q <= WAIT_VS;
            end else begin
              we_q   <= 1'b1;
              addr_q <= base_q;
              data_q <= '0;
              base_q <= base_q + AW'(1);
              if ({1'b0, base_q} == (AW+1)'(TOTAL - 1)) state_q <= WAIT_VS;
            end
          end
`endif
          default: state_q <= WAIT_VS;
        endcase
      end
    end
  end

  assign bus.fb_we      = we_q;
  assign bus.fb_addr    = addr_q;
  assign bus.fb_data    = data_q;
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_tia_fb_writer.sv
// Directed bench for tia_fb_writer with a write scoreboard (addr, data, cycle).
// Honours FB_CLEAR_EN when compiled with it.
module tb_tia_fb_writer;

  localparam int unsigned LP = 160;
  localparam int unsigned NL = 240;
  localparam int unsigned FL = 40;

  typedef struct packed {
    int unsigned cyc;
    logic [15:0] addr;
    logic [6:0]  data;
  } exp_t;

  logic clk;
  logic rst_n;
  tia_fb_writer_if bus();

  tia_fb_writer #(.LINE_PIXELS(LP), .NUM_LINES(NL), .FIRST_LINE(FL)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;
  int unsigned cyc_n    = 0;
  int unsigned done_cnt = 0;
  int unsigned done_cyc = 0;
  exp_t        exp_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every fb_we must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.fb_we) begin
        if (exp_q.size() == 0) begin
          check("spurious_we", 32'(bus.fb_we), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("wr_cycle", cyc_n, e.cyc);
          check("wr_addr", 32'(bus.fb_addr), 32'(e.addr));
          check("wr_data", 32'(bus.fb_data), 32'(e.data));
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc_n) begin
        check("missing_we", 32'(bus.fb_we), 32'd1);
        void'(exp_q.pop_front());
      end
      if (bus.frame_done) begin
        done_cnt++;
        done_cyc = cyc_n;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    bus.pix_en = 1'b0;
    bus.hsync  = 1'b0;
  endtask

  task automatic drive(input logic pen, input logic [6:0] d, input logic hs,
                       input logic exp_wr, input logic [15:0] a);
    bus.pix_en   = pen;
    bus.pix_data = d;
    bus.hsync    = hs;
    if (exp_wr) exp_q.push_back(exp_t'{cyc_n + 1, a, d});
    tick();
  endtask

  task automatic vsync_pulse();
    bus.vsync = 1'b1;
    tick();
    bus.vsync = 1'b0;
    tick();
  endtask

  initial begin
    int unsigned done_exp;
    int unsigned k;
    rst_n        = 1'b1;
    bus.pix_en   = 1'b0;
    bus.pix_data = '0;
    bus.hsync    = 1'b0;
    bus.vsync    = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_we",   32'(bus.fb_we), 32'd0);
    check("rst_addr", 32'(bus.fb_addr), 32'd0);
    check("rst_data", 32'(bus.fb_data), 32'd0);
    check("rst_done", 32'(bus.frame_done), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // WAIT_VS ignores pixels and hsyncs
    repeat (4) drive(1'b1, 7'h12, 1'b1, 1'b0, 16'd0);

    vsync_pulse();
    drive(1'b1, 7'h33, 1'b0, 1'b0, 16'd0);
    for (int i = 0; i < FL; i++) drive(1'b0, 7'h00, 1'b1, 1'b0, 16'd0);

    // line 0: data 0..127 wrapping
    for (int i = 0; i < LP; i++) drive(1'b1, 7'(i), 1'b0, 1'b1, 16'(i));
    // line 1: 200 pixels, only the first LP stored
    drive(1'b0, 7'h00, 1'b1, 1'b0, 16'd0);
    for (int i = 0; i < 200; i++)
      drive(1'b1, 7'(i * 3), 1'b0, (i < LP), 16'(LP + i));
    drive(1'b0, 7'h00, 1'b1, 1'b0, 16'd0);
    drive(1'b1, 7'h2a, 1'b0, 1'b1, 16'd320);
    // line 3: hsync and pixel coincide
    drive(1'b1, 7'h55, 1'b1, 1'b1, 16'd480);
    drive(1'b1, 7'h56, 1'b0, 1'b1, 16'd481);
    for (int l = 4; l < NL - 1; l++) begin
      drive(1'b0, 7'h00, 1'b1, 1'b0, 16'd0);
      drive(1'b1, 7'(l), 1'b0, 1'b1, 16'(l * LP));
    end
    drive(1'b0, 7'h00, 1'b1, 1'b0, 16'd0);
    for (int i = 0; i < LP; i++)
      drive(1'b1, 7'(i + 7), 1'b0, 1'b1, 16'((NL - 1) * LP + i));
    // last hsync: coincident pixel dropped, frame_done next cycle
    done_exp = cyc_n + 1;
    drive(1'b1, 7'h11, 1'b1, 1'b0, 16'd0);
    repeat (5) drive(1'b1, 7'h22, 1'b0, 1'b0, 16'd0);
    repeat (2) drive(1'b0, 7'h00, 1'b1, 1'b0, 16'd0);
    check("hold_addr", 32'(bus.fb_addr), 32'd38399);
    check("hold_data", 32'(bus.fb_data), 32'd38);
    check("done_count", done_cnt, 32'd1);
    check("done_cycle", done_cyc, done_exp);

    // vsync rise from DONE, then a short frame of 10 lines
    bus.vsync = 1'b1;
    repeat (3) drive(1'b1, 7'h44, 1'b0, 1'b0, 16'd0);
    bus.vsync = 1'b0;
    tick();
    for (int i = 0; i < FL; i++) drive(1'b0, 7'h00, 1'b1, 1'b0, 16'd0);
    for (int l = 0; l < 10; l++) begin
      drive(1'b1, 7'(l + 1), 1'b0, 1'b1, 16'(l * LP));
      drive(1'b0, 7'h00, 1'b1, 1'b0, 16'd0);
    end
    bus.vsync = 1'b1;
    k = cyc_n;
`ifdef FB_CLEAR_EN
    for (int a = 1600; a < LP * NL; a++)
      exp_q.push_back(exp_t'{k + 2 + (a - 1600), 16'(a), 7'd0});
    repeat (LP * NL - 1600 + 8) tick();
`else
    repeat (50) tick();
`endif
    check("short_no_done", done_cnt, 32'd1);
    check("short_sb_empty", exp_q.size(), 32'd0);

    // reset asserted mid-line 5
    bus.vsync = 1'b0;
    tick();
    for (int i = 0; i < FL; i++) drive(1'b0, 7'h00, 1'b1, 1'b0, 16'd0);
    repeat (5) drive(1'b0, 7'h00, 1'b1, 1'b0, 16'd0);
    drive(1'b1, 7'h01, 1'b0, 1'b1, 16'd800);
    drive(1'b1, 7'h02, 1'b0, 1'b1, 16'd801);
    drive(1'b1, 7'h03, 1'b0, 1'b0, 16'd0);
    check("pre_rst_we",   32'(bus.fb_we), 32'd1);
    check("pre_rst_addr", 32'(bus.fb_addr), 32'd802);
    rst_n = 1'b0;
    #1;
    check("async_rst_we",   32'(bus.fb_we), 32'd0);
    check("async_rst_addr", 32'(bus.fb_addr), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) drive(1'b1, 7'h09, 1'b0, 1'b0, 16'd0);
    repeat (2) drive(1'b1, 7'h0a, 1'b1, 1'b0, 16'd0);
    vsync_pulse();
    for (int i = 0; i < FL - 1; i++) drive(1'b1, 7'h0b, 1'b1, 1'b0, 16'd0);
    drive(1'b1, 7'h0c, 1'b0, 1'b0, 16'd0);
    drive(1'b0, 7'h00, 1'b1, 1'b0, 16'd0);
    drive(1'b1, 7'h7f, 1'b0, 1'b1, 16'd0);
    repeat (5) tick();
    check("final_sb_empty", exp_q.size(), 32'd0);
    check("final_done_count", done_cnt, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/tia_fb_writer.md
TIA_FB_WRITER -- requirements
Module: tia_fb_writer

Interface
REQ-001 SHALL have parameter LINE_PIXELS, default 160, meaning pixels stored per line; columns at or above it are dropped.
REQ-002 SHALL have parameter NUM_LINES, default 240, meaning lines stored per frame.
REQ-003 SHALL have parameter FIRST_LINE, default 40, meaning hsync pulses skipped after vsync falls before storing starts.
REQ-004 SHALL have port clk  input  1  single system clock; all logic is on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port pix_en  input  1  one-cycle strobe, one per visible pixel.
REQ-007 SHALL have port pix_data  input  7  palette index, valid with pix_en.
REQ-008 SHALL have port hsync  input  1  one-cycle line-start pulse.
REQ-009 SHALL have port vsync  input  1  level, high during vertical sync.
REQ-010 SHALL have port fb_addr  output  16  framebuffer write address, equal to line*LINE_PIXELS + column.
REQ-011 SHALL have port fb_data  output  7  framebuffer write data.
REQ-012 SHALL have port fb_we  output  1  write strobe, one cycle per write.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse when the last line of a frame is complete.

Function
REQ-014 SHALL implement states WAIT_VS, SKIP, ACTIVE, DONE, CLEAR.
REQ-015 SHALL detect vsync edges from a registered copy of vsync; a falling edge in any state moves to SKIP with the line counter at 0, column at 0 and line_base at 0.
REQ-016 In SKIP, each hsync SHALL increment the skip counter; the hsync that makes it equal FIRST_LINE moves to ACTIVE with line 0 and column 0; FIRST_LINE=0 enters ACTIVE directly on the vsync falling edge.
REQ-017 In ACTIVE, pix_en with column < LINE_PIXELS SHALL produce fb_we=1 exactly one cycle later, with fb_addr = line_base + column and fb_data = pix_data; column then increments.
REQ-018 In ACTIVE, pix_en with column >= LINE_PIXELS SHALL be dropped (no write) and the column SHALL saturate (no wrap).
REQ-019 In ACTIVE, hsync SHALL reset the column to 0, add LINE_PIXELS to line_base (no multiplier) and increment the line.
REQ-020 When hsync and pix_en coincide, the hsync SHALL take effect first and the pixel SHALL be written at column 0 of the new line.
REQ-021 The hsync that makes the line equal NUM_LINES SHALL move to DONE and pulse frame_done in the following cycle; a pix_en in that same cycle SHALL be dropped.
REQ-022 In DONE and WAIT_VS, pix_en and hsync SHALL be ignored, and a vsync rising edge moves to WAIT_VS.
REQ-023 In ACTIVE, a vsync rising edge (short frame) SHALL move to CLEAR when FB_CLEAR_EN is defined, else to WAIT_VS; frame_done SHALL NOT pulse for a short frame.
REQ-024 fb_we SHALL be 0 in every cycle where no write is defined; fb_addr and fb_data SHALL hold their last values when fb_we=0.
REQ-025 Address arithmetic SHALL be 16-bit unsigned; LINE_PIXELS*NUM_LINES SHALL not exceed 65536, and a parameter set that exceeds it is illegal.

Reset
REQ-026 reset low SHALL asynchronously force: state WAIT_VS, all counters 0, line_base 0, registered vsync 0, fb_we 0, fb_addr 0, fb_data 0, frame_done 0.
REQ-027 Deasserting reset mid-frame SHALL result in no writes until the next vsync falling edge.

Configuration
REQ-028 With macro FB_CLEAR_EN defined, CLEAR SHALL write fb_data=0 at one address per cycle, from the first address not yet written in the short frame up to LINE_PIXELS*NUM_LINES-1, then enter WAIT_VS; a vsync falling edge during CLEAR SHALL abort it and enter SKIP.
REQ-029 Without FB_CLEAR_EN, CLEAR SHALL not exist, short frames SHALL leave stale framebuffer contents, and no logic for it SHALL be synthesized.

Verification
REQ-030 Reset, vsync pulse, 40 hsyncs, 160 pix_en with data 0..127 wrapping -> 160 writes at addr 0..159 with matching data, each 1 cycle after pix_en.
REQ-031 Full frame of 240 lines at 160 px -> last write addr 38399, frame_done pulses once, then no writes until the next vsync.
REQ-032 200 pix_en on one line -> exactly 160 writes; next line's first write at addr 160.
REQ-033 hsync and pix_en coincident (data 0x55) on line 3 -> write addr 480, data 0x55.
REQ-034 FB_CLEAR_EN defined, vsync rises after line 10 col 0 -> zero writes at addr 1600..38399 on consecutive cycles, no frame_done; without the macro -> no writes.
REQ-035 reset asserted mid-line 5 -> fb_we drops to 0 immediately, and no writes occur until a vsync fall plus 40 hsyncs.
